// File: rtl/inst_pair_fetch_if.sv
// Single-word, one-outstanding instruction bus; master = pair fetcher, slave = SRAM-like memory.
interface inst_pair_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, addr, input addr_ok, data_ok, rdata);
    modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/inst_pair_fetch.sv
// Instruction pair fetch: reads F_pc and F_pc+4 over the bus and returns both words with per-slot valids.
// Latency: 1 + words*(addr wait + 1 + data wait) cycles; 1 cycle for a misaligned pc or a pair-buffer hit.
// Backpressure: req/addr held until addr_ok; dropping inst_sram_en cancels and drains any accepted read.
// Optional one-entry pair buffer: define INST_PAIR_BUF_EN.
module inst_pair_fetch #(
    parameter int PAGE_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic [31:0]       F_pc,
    output logic              inst_data_ok,
    output logic              inst_data_ok1,
    output logic              inst_data_ok2,
    output logic [31:0]       inst_rdata1,
    output logic [31:0]       inst_rdata2,
    output logic              i_stall,
    inst_pair_fetch_if.master ibus
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] cap1;
    logic        busy_q;
    logic        slave_ok;
    logic        hit;

    logic        buf_vld;
    logic [31:0] buf_pc;
    logic [31:0] buf_d1;
    logic [31:0] buf_d2;
    logic        buf_ok1;
    logic        buf_ok2;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is already physical.
    function automatic logic [31:0] map_addr(input logic [31:0] a);
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101)
            return {3'b000, a[28:0]};
        return a;
    endfunction

    assign pc_next  = pc_q + 32'd4;
    assign slave_ok = ~(&pc_q[PAGE_BITS-1:2]);
    assign hit      = buf_vld & (F_pc == buf_pc);
    assign i_stall  = busy_q | ((state == IDLE) & rst & inst_sram_en & ~hit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            pc_q          <= '0;
            cap1          <= '0;
            busy_q        <= 1'b0;
            ibus.req      <= 1'b0;
            ibus.addr     <= '0;
            inst_data_ok  <= 1'b0;
            inst_data_ok1 <= 1'b0;
            inst_data_ok2 <= 1'b0;
            inst_rdata1   <= '0;
            inst_rdata2   <= '0;
        end else begin
            inst_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_sram_en) begin
                        pc_q <= F_pc;
                        if (F_pc[1:0] != 2'b00) begin
                            state         <= DONE;
                            inst_data_ok  <= 1'b1;
                            inst_data_ok1 <= 1'b0;
                            inst_data_ok2 <= 1'b0;
                        end else if (hit) begin
                            state         <= DONE;
                            inst_data_ok  <= 1'b1;
                            inst_data_ok1 <= buf_ok1;
                            inst_data_ok2 <= buf_ok2;
                            inst_rdata1   <= buf_d1;
                            inst_rdata2   <= buf_d2;
                        end else begin
                            state     <= REQ1;
                            busy_q    <= 1'b1;
                            ibus.req  <= 1'b1;
                            ibus.addr <= map_addr(F_pc);
                        end
                    end
                end
                REQ1, REQ2: begin
                    if (ibus.addr_ok) begin
                        ibus.req <= 1'b0;
                        if (!inst_sram_en) begin
                            state  <= DRAIN;
                            busy_q <= 1'b0;
                        end else begin
                            state <= (state == REQ1) ? WAIT1 : WAIT2;
                        end
                    end else if (!inst_sram_en) begin
                        ibus.req <= 1'b0;
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                WAIT1, WAIT2: begin
                    if (!inst_sram_en) begin
                        // A read returning in the cancel cycle needs no drain.
                        state  <= ibus.data_ok ? IDLE : DRAIN;
                        busy_q <= 1'b0;
                    end else if (ibus.data_ok) begin
                        if (state == WAIT1 && slave_ok) begin
                            cap1      <= ibus.rdata;
                            state     <= REQ2;
                            ibus.req  <= 1'b1;
                            ibus.addr <= map_addr(pc_next);
                        end else begin
                            state         <= DONE;
                            busy_q        <= 1'b0;
                            inst_data_ok  <= 1'b1;
                            inst_data_ok1 <= 1'b1;
                            if (state == WAIT1) begin
                                inst_rdata1   <= ibus.rdata;
                                inst_data_ok2 <= 1'b0;
                            end else begin
                                inst_rdata1   <= cap1;
                                inst_rdata2   <= ibus.rdata;
                                inst_data_ok2 <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (ibus.data_ok)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INST_PAIR_BUF_EN
    logic cancel;

    assign cancel = ~inst_sram_en &
                    ((state == REQ1) | (state == WAIT1) | (state == REQ2) | (state == WAIT2));

    // ok1 is set only by a bus read (or a prior hit), so it marks pairs worth keeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_pc  <= '0;
            buf_d1  <= '0;
            buf_d2  <= '0;
            buf_ok1 <= 1'b0;
            buf_ok2 <= 1'b0;
        end else if (cancel) begin
            buf_vld <= 1'b0;
        end else if (state == DONE && inst_data_ok1) begin
            buf_vld <= 1'b1;
            buf_pc  <= pc_q;
            buf_d1  <= inst_rdata1;
            buf_d2  <= inst_rdata2;
            buf_ok1 <= inst_data_ok1;
            buf_ok2 <= inst_data_ok2;
        end
    end
`else
    assign buf_vld = 1'b0;
    assign buf_pc  = '0;
    assign buf_d1  = '0;
    assign buf_d2  = '0;
    assign buf_ok1 = 1'b0;
    assign buf_ok2 = 1'b0;
`endif

endmodule

// File: tb/tb_inst_pair_fetch.sv
// Bench for inst_pair_fetch: directed vector table, cancellation sequences, randomized fetches vs reference model.
module tb_inst_pair_fetch;

    localparam int PAGE_BITS = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [31:0] F_pc = '0;
    logic        inst_data_ok;
    logic        inst_data_ok1;
    logic        inst_data_ok2;
    logic [31:0] inst_rdata1;
    logic [31:0] inst_rdata2;
    logic        i_stall;

    inst_pair_fetch_if bus();

    inst_pair_fetch #(.PAGE_BITS(PAGE_BITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_sram_en  (inst_sram_en),
        .F_pc          (F_pc),
        .inst_data_ok  (inst_data_ok),
        .inst_data_ok1 (inst_data_ok1),
        .inst_data_ok2 (inst_data_ok2),
        .inst_rdata1   (inst_rdata1),
        .inst_rdata2   (inst_rdata2),
        .i_stall       (i_stall),
        .ibus          (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int          a_dly = 0;
    int          d_dly = 1;
    int          acc_cnt = 0;
    int          unstable = 0;
    logic [31:0] acc_addr [0:1023];

    bit          mbuf_vld = 1'b0;
    logic [31:0] mbuf_pc = '0;
    bit          mbuf_ok2 = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    function automatic bit same_page(input logic [31:0] pc);
        longint p0, p1;
        p0 = longint'(pc) >> PAGE_BITS;
        p1 = (longint'(pc) + 4) >> PAGE_BITS;
        return p0 == p1;
    endfunction

    task automatic chk(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", what, got, exp);
        end
    endtask

    // Memory slave: addr_ok after a_dly waiting cycles, data a d_dly cycles after acceptance.
    initial begin : slave
        int          req_age;
        int          pend_age;
        bit          pend;
        logic [31:0] pend_addr;
        logic [31:0] last_addr;
        req_age = 0; pend_age = 0; pend = 1'b0; pend_addr = '0; last_addr = '0;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
        forever begin
            @(negedge clk);
            bus.addr_ok = 1'b0;
            bus.data_ok = 1'b0;
            bus.rdata   = 32'hDEAD_BEEF;
            if (!rst) begin
                req_age = 0;
                pend    = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_age >= d_dly) begin
                        bus.data_ok = 1'b1;
                        bus.rdata   = memf(pend_addr);
                        pend        = 1'b0;
                    end else begin
                        pend_age++;
                    end
                end
                if (bus.req && !pend) begin
                    if (req_age > 0 && bus.addr != last_addr) unstable++;
                    last_addr = bus.addr;
                    if (req_age >= a_dly) begin
                        bus.addr_ok = 1'b1;
                        acc_addr[acc_cnt % 1024] = bus.addr;
                        acc_cnt++;
                        pend      = 1'b1;
                        pend_age  = 1;
                        pend_addr = bus.addr;
                        req_age   = 0;
                    end else begin
                        req_age++;
                    end
                end else begin
                    req_age = 0;
                end
            end
        end
    end

    task automatic run_fetch(input string name, input logic [31:0] pc, input int a, input int d,
                             input int exp_lat, input bit exp_ok1, input bit exp_ok2,
                             input int exp_n, input logic [31:0] exp_a1, input bit exp_stall0);
        int          acc0;
        int          cyc;
        bit          done;
        bit          stall_ok;
        logic [31:0] got1;
        logic [31:0] got2;
        a_dly = a;
        d_dly = d;
        @(negedge clk);
        acc0 = acc_cnt;
        inst_sram_en = 1'b1;
        F_pc = pc;
        #1;
        stall_ok = (i_stall == exp_stall0);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (inst_data_ok) begin
                done = 1'b1;
                if (i_stall) stall_ok = 1'b0;
            end else if (!i_stall) begin
                stall_ok = 1'b0;
            end
        end
        inst_sram_en = 1'b0;
        chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, "_stall"}, 32'(stall_ok), 32'd1);
        chk({name, "_ok1"}, 32'(inst_data_ok1), 32'(exp_ok1));
        chk({name, "_ok2"}, 32'(inst_data_ok2), 32'(exp_ok2));
        if (exp_ok1) chk({name, "_rdata1"}, inst_rdata1, memf(phys(pc)));
        if (exp_ok2) chk({name, "_rdata2"}, inst_rdata2, memf(phys(pc + 32'd4)));
        got1 = (acc_cnt > acc0)     ? acc_addr[acc0 % 1024]       : 32'h0;
        got2 = (acc_cnt > acc0 + 1) ? acc_addr[(acc0 + 1) % 1024] : 32'h0;
        chk({name, "_nreq"}, 32'(acc_cnt - acc0), 32'(exp_n));
        if (exp_n > 0) chk({name, "_addr1"}, got1, exp_a1);
        if (exp_n > 1) chk({name, "_addr2"}, got2, exp_a1 + 32'd4);
        chk({name, "_addr_stable"}, 32'(unstable), 32'd0);
`ifdef INST_PAIR_BUF_EN
        if (exp_n > 0) begin
            mbuf_vld = 1'b1;
            mbuf_pc  = pc;
            mbuf_ok2 = exp_ok2;
        end
`endif
    endtask

    task automatic model_fetch(input string name, input logic [31:0] pc, input int a, input int d);
        int lat;
        int n;
        bit o1;
        bit o2;
        bit hit;
        hit = 1'b0;
        if (pc % 4 != 0) begin
            lat = 1; n = 0; o1 = 1'b0; o2 = 1'b0;
        end
`ifdef INST_PAIR_BUF_EN
        else if (mbuf_vld && pc == mbuf_pc) begin
            hit = 1'b1; lat = 1; n = 0; o1 = 1'b1; o2 = mbuf_ok2;
        end
`endif
        else begin
            n   = same_page(pc) ? 2 : 1;
            lat = 1 + n * (a + 1 + d);
            o1  = 1'b1;
            o2  = (n == 2);
        end
        run_fetch(name, pc, a, d, lat, o1, o2, n, phys(pc), !hit);
    endtask

    typedef struct {
        logic [31:0] pc;
        int          a;
        int          d;
        int          lat;
        bit          ok1;
        bit          ok2;
        int          n;
        logic [31:0] addr1;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] pool [5];

    initial begin : main
        logic [31:0] pc;
        logic [31:0] prev_pc;
        int          acc0;
        bit          seen_ok;
        bit          seen_stall;

        vecs[0] = '{32'hBFC0_0000, 0, 1,  5, 1'b1, 1'b1, 2, 32'h1FC0_0000};
        vecs[1] = '{32'h8000_0FFC, 0, 1,  3, 1'b1, 1'b0, 1, 32'h0000_0FFC};
        vecs[2] = '{32'h8000_0002, 0, 1,  1, 1'b0, 1'b0, 0, 32'h0000_0000};
        vecs[3] = '{32'h0040_0000, 2, 3, 13, 1'b1, 1'b1, 2, 32'h0040_0000};
        vecs[4] = '{32'h8000_0FF8, 0, 1,  5, 1'b1, 1'b1, 2, 32'h0000_0FF8};
        vecs[5] = '{32'h1234_5FFC, 1, 2,  5, 1'b1, 1'b0, 1, 32'h1234_5FFC};
        vecs[6] = '{32'hA000_1003, 0, 1,  1, 1'b0, 1'b0, 0, 32'h0000_0000};
        vecs[7] = '{32'hC000_0010, 1, 1,  7, 1'b1, 1'b1, 2, 32'hC000_0010};
        pool[0] = 32'hBFC0_0000;
        pool[1] = 32'h8000_0FF8;
        pool[2] = 32'h0000_1000;
        pool[3] = 32'h9FFF_FFF8;
        pool[4] = 32'hA000_0FF8;

        // Reset held with a request pending.
        rst = 1'b0;
        inst_sram_en = 1'b1;
        F_pc = 32'hBFC0_0000;
        repeat (3) @(negedge clk);
        chk("reset_req", 32'(bus.req), 32'd0);
        chk("reset_addr", bus.addr, 32'd0);
        chk("reset_stall", 32'(i_stall), 32'd0);
        chk("reset_flags", {29'd0, inst_data_ok, inst_data_ok1, inst_data_ok2}, 32'd0);
        chk("reset_rdata", inst_rdata1 | inst_rdata2, 32'd0);
        rst = 1'b1;
        inst_sram_en = 1'b0;

        for (int i = 0; i < 8; i++)
            run_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].a, vecs[i].d, vecs[i].lat,
                      vecs[i].ok1, vecs[i].ok2, vecs[i].n, vecs[i].addr1, 1'b1);

        // Cancel in WAIT1: accepted read must be drained, no completion pulse.
        a_dly = 0;
        d_dly = 3;
        @(negedge clk);
        acc0 = acc_cnt;
        inst_sram_en = 1'b1;
        F_pc = 32'h0000_2000;
        @(negedge clk);
        @(negedge clk);
        inst_sram_en = 1'b0;
        seen_ok = 1'b0;
        seen_stall = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (inst_data_ok) seen_ok = 1'b1;
            if (i_stall) seen_stall = 1'b1;
        end
        chk("cancel_wait1_no_ok", 32'(seen_ok), 32'd0);
        chk("cancel_wait1_no_stall", 32'(seen_stall), 32'd0);
        chk("cancel_wait1_nreq", 32'(acc_cnt - acc0), 32'd1);
        mbuf_vld = 1'b0;
        model_fetch("after_cancel", 32'h0000_3000, 0, 1);

        // Cancel in REQ1 before addr_ok: request withdrawn, nothing accepted.
        a_dly = 3;
        @(negedge clk);
        acc0 = acc_cnt;
        inst_sram_en = 1'b1;
        F_pc = 32'h0000_3000;
        @(negedge clk);
        chk("cancel_req1_req_up", 32'(bus.req), 32'd1);
        inst_sram_en = 1'b0;
        @(negedge clk);
        chk("cancel_req1_req_drop", 32'(bus.req), 32'd0);
        repeat (5) @(negedge clk);
        chk("cancel_req1_nreq", 32'(acc_cnt - acc0), 32'd0);
        mbuf_vld = 1'b0;
        model_fetch("after_cancel2", 32'h0000_3000, 0, 1);

`ifdef INST_PAIR_BUF_EN
        model_fetch("buf_fill", 32'h8000_4000, 0, 1);
        model_fetch("buf_hit", 32'h8000_4000, 0, 1);
        model_fetch("buf_miss", 32'h8000_4010, 0, 1);
`endif

        prev_pc = 32'h8000_4010;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                pc = prev_pc;
            else
                pc = pool[$urandom_range(0, 4)] + 32'(4 * $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                pc[1:0] = 2'($urandom_range(1, 3));
            model_fetch($sformatf("rnd%0d", i), pc, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
            prev_pc = pc;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_pair_fetch.md
# inst_pair_fetch

Instruction-fetch responder between the dual-issue datapath's fetch port and a single-word, one-outstanding SRAM-like instruction bus. For each fetch request at `F_pc` it reads `F_pc` and `F_pc+4` and returns both words together with per-slot valid flags (`inst_data_ok1/2`), which feed the instruction FIFO's two write ports. It also drives `i_stall` to the hazard unit while a fetch is in flight.

## Interface
Parameters:
- `PAGE_BITS`, 12: slave-word fetch is suppressed when `F_pc+4` crosses a 2^PAGE_BITS-byte boundary.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `inst_sram_en`  in  1  fetch request, level; sampled in IDLE.
- `F_pc`  in  32  fetch address; sampled and latched in IDLE.
- `inst_data_ok`  out  1  one-cycle pulse: the fetch pair is complete.
- `inst_data_ok1`  out  1  with `inst_data_ok`: `inst_rdata1` is valid.
- `inst_data_ok2`  out  1  with `inst_data_ok`: `inst_rdata2` is valid.
- `inst_rdata1`  out  32  instruction at the latched pc.
- `inst_rdata2`  out  32  instruction at latched pc+4.
- `i_stall`  out  1  fetch in progress; the datapath holds `F_pc`.
- `ibus_req`  out  1  bus read request.
- `ibus_addr`  out  32  physical word address.
- `ibus_addr_ok`  in  1  request accepted in this cycle (`ibus_req & ibus_addr_ok`).
- `ibus_data_ok`  in  1  read data returned in this cycle.
- `ibus_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE, DRAIN.
- **IDLE**
  - If `inst_sram_en=0`: stay in IDLE.
  - If `inst_sram_en=1`: latch `F_pc` into `pc_q`.
  - If `F_pc[1:0]!=0`: go to DONE with ok1=ok2=0 and no bus access.
  - Otherwise go to REQ1.
- **REQ1**: `ibus_req=1`, `ibus_addr=map(pc_q)`. On `addr_ok`, go to WAIT1.
- **WAIT1**: on `data_ok`, capture `ibus_rdata` into `rdata1` and set ok1.
  - If the slave word is allowed, go to REQ2.
  - Otherwise go to DONE.
- **Slave-word rule**: the slave word is allowed iff `pc_q[PAGE_BITS-1:2]` is not all ones.
- **REQ2 / WAIT2**: same as REQ1/WAIT1 with address `pc_q+4`, capturing into `rdata2` and setting ok2. After WAIT2, go to DONE.
- **DONE**: `inst_data_ok=1` for exactly one cycle, then back to IDLE.
- **Address map**:
  - `pc_q[31:29]` = 3'b100 or 3'b101 (kseg0/kseg1): `map(a) = {3'b000, a[28:0]}`.
  - Otherwise the address passes through unchanged.
- **Cancellation**: if `inst_sram_en` falls during REQ2, WAIT1 or WAIT2 while a bus transaction is accepted but not yet returned:
  - go to DRAIN, wait for `data_ok`, discard the data, return to IDLE with no `inst_data_ok`.
  - If it falls in REQ1 before `addr_ok`, or in REQ2 before `addr_ok`, return to IDLE immediately.
  - `ibus_req` drops that same cycle.
- **Output hold**: `inst_rdata1/2` and `inst_data_ok1/2` hold their last values outside DONE. Only the `inst_data_ok` pulse qualifies them.
- **Stall**: `i_stall = (state==IDLE & inst_sram_en & ~hit) | state ∈ {REQ1, WAIT1, REQ2, WAIT2}`. It is 0 in DONE and in DRAIN.

## Timing
- **Reset** (`rst=0` at an edge): state=IDLE, and all outputs are 0 (`ibus_addr=0`, rdata=0, ok flags=0, `i_stall=0`). Reset overrides any in-flight transaction; late `ibus_data_ok` after reset is ignored in IDLE.
- **Zero-wait bus** (`addr_ok` in the request cycle, `data_ok` one cycle later):
  - c0 IDLE, c1 REQ1, c2 WAIT1, c3 REQ2, c4 WAIT2, c5 DONE.
  - `inst_data_ok` is high 5 cycles after the request is sampled.
- **Single-word fetch**: DONE at c3.
- **Misaligned pc**: DONE at c1.
- **Bus protocol**: `ibus_addr` is stable while `ibus_req=1` and `addr_ok=0`. At most one outstanding read. `ibus_data_ok` outside WAIT1/WAIT2/DRAIN is ignored.
- **Next request**: sampled in the IDLE cycle after DONE, so there is no back-to-back DONE without the buffer.

## Configuration
- Macro `INST_PAIR_BUF_EN`.
- **Defined**: a one-entry pair buffer holds {valid, `pc_q`, rdata1/2, ok1/2}.
  - Filled at every DONE that had a bus access.
  - In IDLE with `inst_sram_en=1` and `F_pc==buf_pc` and valid: go straight to DONE with the buffered data. Latency is 1 cycle, with no bus access and `i_stall=0`.
  - valid is cleared by reset and by cancellation.
- **Undefined**: no buffer; every aligned request goes to the bus.

## Test plan
- **Reset**: hold `rst=0` for 3 cycles with `inst_sram_en=1` -> all outputs 0, `ibus_req=0`. After release with `F_pc=0xBFC00000`:
  - `ibus_addr=0x1FC00000`, then `0x1FC00004`.
  - `inst_data_ok` pulses at c5 with ok1=ok2=1 and data matching memory.
- **Page end**: `F_pc=0x80000FFC` -> one bus read at `0x00000FFC`; DONE with ok1=1, ok2=0.
- **Misaligned**: `F_pc=0x80000002` -> no `ibus_req`; `inst_data_ok=1`, ok1=ok2=0 at c1.
- **Wait states**: `addr_ok` delayed 2 cycles, `data_ok` delayed 3 cycles -> `ibus_addr` stable throughout, `i_stall` high until DONE, exactly 2 accepted requests.
- **Cancellation**: drop `inst_sram_en` in WAIT1 -> DRAIN absorbs `data_ok`, no `inst_data_ok`. The next request at a new pc returns correct data.
- **Buffer** (`INST_PAIR_BUF_EN`): repeat the same `F_pc` -> `inst_data_ok` at c1, no `ibus_req`, identical data. A different pc -> full bus fetch.
